pa_cp0_fcsr_mwb: RTL and testbench

PA_CP0_FCSR_MWB -- requirements
Module: pa_cp0_fcsr_mwb

---
 rtl/pa_cp0_fcsr_mwb.sv | 167 ++++++++++++++++
 tb/tb_pa_cp0_fcsr_mwb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_cp0_fcsr_mwb.sv
// FP control/status CSRs (frm, fflags, fxcr) with staged merge of FPU write-back flags.
// Optional FP-exception trap request logic is enabled by defining PA_CP0_FCSR_FPE_TRAP_EN.
module pa_cp0_fcsr_mwb #(
    parameter int WB_PORTS = 2
) (
    input  logic                  regs_clk,
    input  logic                  cpurst_b,
    input  logic                  fcsr_local_en,
    input  logic                  fflags_local_en,
    input  logic                  frm_local_en,
    input  logic                  fxcr_local_en,
    input  logic [31:0]           iui_regs_wdata,
    input  logic [WB_PORTS-1:0]   fpu_cp0_wb_fflags_updt,
    input  logic [5*WB_PORTS-1:0] fpu_cp0_wb_fflags,
    input  logic                  rtu_cp0_fpe_ack,
    output logic [31:0]           fcsr_value,
    output logic [31:0]           fflags_value,
    output logic [31:0]           frm_value,
    output logic [31:0]           fxcr_value,
    output logic [2:0]            cp0_fpu_xx_rm,
    output logic [2:0]            cp0_idu_rm,
    output logic                  cp0_fpu_xx_dqnan,
    output logic                  cp0_idu_fflags_pend,
    output logic                  cp0_rtu_fpe_req,
    output logic [4:0]            cp0_rtu_fpe_cause
);

    logic [2:0] frm;
    logic [4:0] fflags;
    logic       fe;
    logic       dqnan;
    logic [4:0] trap_en;
    logic       stage_vld;
    logic [4:0] stage_flags;
    logic       wb_any;
    logic [4:0] wb_flags;
    logic       fflags_wr;
    logic       merge;

    assign fflags_wr = fcsr_local_en | fflags_local_en | fxcr_local_en;
    // A CSR write to the flags wins over the staged update, which is then dropped.
    assign merge     = stage_vld & ~fflags_wr;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wb_any   = 1'b0;
        wb_flags = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (fpu_cp0_wb_fflags_updt[p]) begin
                wb_any   = 1'b1;
                wb_flags = wb_flags | fpu_cp0_wb_fflags[5*p +: 5];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge regs_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            stage_vld   <= 1'b0;
            stage_flags <= '0;
        end else begin
            stage_vld   <= wb_any;
            stage_flags <= wb_flags;
        end
    end

    always_ff @(posedge regs_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            frm    <= '0;
            fflags <= '0;
            fe     <= 1'b0;
            dqnan  <= 1'b0;
        end else begin
            if (fcsr_local_en)
                frm <= iui_regs_wdata[7:5];
            else if (frm_local_en)
                frm <= iui_regs_wdata[2:0];
            else if (fxcr_local_en)
                frm <= iui_regs_wdata[26:24];

            if (fflags_wr)
                fflags <= iui_regs_wdata[4:0];
            else if (merge)
                fflags <= fflags | stage_flags;

            if (fxcr_local_en)
                fe <= iui_regs_wdata[5];
            else if (merge)
                fe <= fe | (|stage_flags);

            if (fxcr_local_en)
                dqnan <= iui_regs_wdata[23];
        end
    end

`ifdef PA_CP0_FCSR_FPE_TRAP_EN
    typedef enum logic {
        FPE_IDLE,
        FPE_REQ
    } fpe_state_e;

    fpe_state_e fpe_state;
    logic [4:0] cause;
    logic [4:0] hit;
    logic       unused_wdata;

    assign hit = merge ? (stage_flags & trap_en) : 5'b0;

    always_ff @(posedge regs_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            trap_en   <= '0;
            fpe_state <= FPE_IDLE;
            cause     <= '0;
        end else begin
            if (fxcr_local_en)
                trap_en <= iui_regs_wdata[12:8];

            case (fpe_state)
                FPE_IDLE: begin
                    if (|hit) begin
                        fpe_state <= FPE_REQ;
                        cause     <= hit;
                    end
                end
                FPE_REQ: begin
                    // An ack retires the old cause; a hit in the same cycle starts a fresh request.
                    if (rtu_cp0_fpe_ack) begin
                        if (|hit) begin
                            cause <= hit;
                        end else begin
                            fpe_state <= FPE_IDLE;
                            cause     <= '0;
                        end
                    end else begin
                        cause <= cause | hit;
                    end
                end
                default: begin
                    fpe_state <= FPE_IDLE;
                    cause     <= '0;
                end
            endcase
        end
    end

    assign cp0_rtu_fpe_req   = (fpe_state == FPE_REQ);
    assign cp0_rtu_fpe_cause = cause;
    assign unused_wdata      = ^{iui_regs_wdata[31:27], iui_regs_wdata[22:13]};
`else
    logic unused_inputs;

    assign trap_en           = '0;
    assign cp0_rtu_fpe_req   = 1'b0;
    assign cp0_rtu_fpe_cause = '0;
    assign unused_inputs     = ^{iui_regs_wdata[31:27], iui_regs_wdata[22:8], rtu_cp0_fpe_ack};
`endif

    assign frm_value           = {29'b0, frm};
    assign fflags_value        = {27'b0, fflags};
    assign fcsr_value          = {24'b0, frm, fflags};
    assign fxcr_value          = {5'b0, frm, dqnan, 10'b0, trap_en, 2'b0, fe, fflags};
    assign cp0_fpu_xx_rm       = frm;
    assign cp0_idu_rm          = frm;
    assign cp0_fpu_xx_dqnan    = dqnan;
    assign cp0_idu_fflags_pend = stage_vld;

endmodule

// File: tb/tb_pa_cp0_fcsr_mwb.sv
// Self-checking bench for pa_cp0_fcsr_mwb: queue-based reference model compared every cycle,
// plus directed literal checks. Trap scenarios run when PA_CP0_FCSR_FPE_TRAP_EN is defined.
module tb_pa_cp0_fcsr_mwb;

    localparam int WB_PORTS = 2;

    logic                  regs_clk = 1'b0;
    logic                  cpurst_b = 1'b0;
    logic                  fcsr_local_en = 1'b0;
    logic                  fflags_local_en = 1'b0;
    logic                  frm_local_en = 1'b0;
    logic                  fxcr_local_en = 1'b0;
    logic [31:0]           iui_regs_wdata = '0;
    logic [WB_PORTS-1:0]   fpu_cp0_wb_fflags_updt = '0;
    logic [5*WB_PORTS-1:0] fpu_cp0_wb_fflags = '0;
    logic                  rtu_cp0_fpe_ack = 1'b0;
    logic [31:0]           fcsr_value, fflags_value, frm_value, fxcr_value;
    logic [2:0]            cp0_fpu_xx_rm, cp0_idu_rm;
    logic                  cp0_fpu_xx_dqnan, cp0_idu_fflags_pend, cp0_rtu_fpe_req;
    logic [4:0]            cp0_rtu_fpe_cause;

    int n_checks = 0;
    int n_fails  = 0;
    bit cmp_en   = 1'b0;

    pa_cp0_fcsr_mwb #(.WB_PORTS(WB_PORTS)) dut (
        .regs_clk               (regs_clk),
        .cpurst_b               (cpurst_b),
        .fcsr_local_en          (fcsr_local_en),
        .fflags_local_en        (fflags_local_en),
        .frm_local_en           (frm_local_en),
        .fxcr_local_en          (fxcr_local_en),
        .iui_regs_wdata         (iui_regs_wdata),
        .fpu_cp0_wb_fflags_updt (fpu_cp0_wb_fflags_updt),
        .fpu_cp0_wb_fflags      (fpu_cp0_wb_fflags),
        .rtu_cp0_fpe_ack        (rtu_cp0_fpe_ack),
        .fcsr_value             (fcsr_value),
        .fflags_value           (fflags_value),
        .frm_value              (frm_value),
        .fxcr_value             (fxcr_value),
        .cp0_fpu_xx_rm          (cp0_fpu_xx_rm),
        .cp0_idu_rm             (cp0_idu_rm),
        .cp0_fpu_xx_dqnan       (cp0_fpu_xx_dqnan),
        .cp0_idu_fflags_pend    (cp0_idu_fflags_pend),
        .cp0_rtu_fpe_req        (cp0_rtu_fpe_req),
        .cp0_rtu_fpe_cause      (cp0_rtu_fpe_cause)
    );

    always #5 regs_clk = ~regs_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural CSR contents plus a queue of flag sets in flight.
    logic [2:0] m_frm;
    logic [4:0] m_ff, m_ten, m_cause, m_pf, m_hit, m_acc;
    logic       m_fe, m_dq, m_req, m_have, m_any, m_wr;
    logic [4:0] pend_q[$];

    always @(posedge regs_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            m_frm = '0; m_ff = '0; m_fe = 1'b0; m_dq = 1'b0; m_ten = '0;
            m_req = 1'b0; m_cause = '0;
            pend_q.delete();
        end else begin
            m_have = (pend_q.size() > 0);
            m_pf   = m_have ? pend_q.pop_front() : 5'b0;
            m_wr   = fcsr_local_en | fflags_local_en | fxcr_local_en;
            m_have = m_have & ~m_wr;
`ifdef PA_CP0_FCSR_FPE_TRAP_EN
            m_hit = m_have ? (m_pf & m_ten) : 5'b0;
            if (m_req && rtu_cp0_fpe_ack) begin
                m_cause = m_hit;
                m_req   = (m_hit != 0);
            end else if (m_hit != 0) begin
                m_req   = 1'b1;
                m_cause = m_cause | m_hit;
            end
            if (fxcr_local_en) m_ten = iui_regs_wdata[12:8];
`endif
            if (fcsr_local_en)        m_frm = iui_regs_wdata[7:5];
            else if (frm_local_en)    m_frm = iui_regs_wdata[2:0];
            else if (fxcr_local_en)   m_frm = iui_regs_wdata[26:24];
            if (m_wr)                 m_ff = iui_regs_wdata[4:0];
            else if (m_have)          m_ff = m_ff | m_pf;
            if (fxcr_local_en)        m_fe = iui_regs_wdata[5];
            else if (m_have && m_pf != 0) m_fe = 1'b1;
            if (fxcr_local_en)        m_dq = iui_regs_wdata[23];
            m_any = 1'b0; m_acc = '0;
            for (int p = 0; p < WB_PORTS; p++)
                if (fpu_cp0_wb_fflags_updt[p]) begin
                    m_any = 1'b1;
                    m_acc = m_acc | fpu_cp0_wb_fflags[5*p +: 5];
                end
            if (m_any) pend_q.push_back(m_acc);
        end
    end

    always @(negedge regs_clk) begin
        if (cmp_en) begin
            check("frm_value",    frm_value,    {29'b0, m_frm});
            check("fflags_value", fflags_value, {27'b0, m_ff});
            check("fcsr_value",   fcsr_value,   {24'b0, m_frm, m_ff});
            check("fxcr_value",   fxcr_value,   {5'b0, m_frm, m_dq, 10'b0, m_ten, 2'b0, m_fe, m_ff});
            check("rm",           {26'b0, cp0_fpu_xx_rm, cp0_idu_rm}, {26'b0, m_frm, m_frm});
            check("dqnan",        {31'b0, cp0_fpu_xx_dqnan}, {31'b0, m_dq});
            check("pend",         {31'b0, cp0_idu_fflags_pend}, {31'b0, pend_q.size() > 0});
            check("fpe_req",      {31'b0, cp0_rtu_fpe_req}, {31'b0, m_req});
            check("fpe_cause",    {27'b0, cp0_rtu_fpe_cause}, {27'b0, m_cause});
        end
    end

    // Apply one cycle of stimulus, then sample just after the edge.
    task automatic cyc(input logic [3:0] en, input logic [31:0] wd, input logic [1:0] updt,
                       input logic [9:0] flags, input logic ack);
        @(negedge regs_clk);
        {fcsr_local_en, fflags_local_en, frm_local_en, fxcr_local_en} = en;
        iui_regs_wdata         = wd;
        fpu_cp0_wb_fflags_updt = updt;
        fpu_cp0_wb_fflags      = flags;
        rtu_cp0_fpe_ack        = ack;
        @(posedge regs_clk);
        #1;
        {fcsr_local_en, fflags_local_en, frm_local_en, fxcr_local_en} = 4'b0;
        iui_regs_wdata         = '0;
        fpu_cp0_wb_fflags_updt = '0;
        fpu_cp0_wb_fflags      = '0;
        rtu_cp0_fpe_ack        = 1'b0;
    endtask

    task automatic idle();
        cyc(4'b0, 32'h0, 2'b0, 10'h0, 1'b0);
    endtask

    localparam logic [3:0] EN_FCSR = 4'b1000, EN_FFLAGS = 4'b0100, EN_FRM = 4'b0010, EN_FXCR = 4'b0001;

    initial begin
        repeat (3) @(posedge regs_clk);
        #1;
        check("reset fcsr",  fcsr_value, 32'h0);
        check("reset fxcr",  fxcr_value, 32'h0);
        check("reset pend",  {31'b0, cp0_idu_fflags_pend}, 32'h0);
        @(negedge regs_clk);
        cpurst_b = 1'b1;
        cmp_en   = 1'b1;
        idle();

        // Two ports report in the same cycle: flags OR together, pend then visible value.
        cyc(4'b0, 32'h0, 2'b11, {5'b10000, 5'b00001}, 1'b0);
        check("wb pend N+1",   {31'b0, cp0_idu_fflags_pend}, 32'h1);
        check("wb fflags N+1", fflags_value, 32'h0);
        idle();
        check("wb fflags N+2", fflags_value, 32'h11);
        check("wb fe N+2",     {31'b0, fxcr_value[5]}, 32'h1);

        // CSR write discards a staged update; fe keeps its old value.
        cyc(4'b0, 32'h0, 2'b01, 10'b00000_00100, 1'b0);
        cyc(EN_FFLAGS, 32'h0, 2'b00, 10'h0, 1'b0);
        check("discard fflags", fflags_value, 32'h0);
        check("discard fe",     {31'b0, fxcr_value[5]}, 32'h1);
        check("discard pend",   {31'b0, cp0_idu_fflags_pend}, 32'h0);
        idle();
        check("discard stays",  fflags_value, 32'h0);

        // fcsr beats frm for the rounding mode.
        cyc(EN_FCSR | EN_FRM, 32'h0000_00E3, 2'b0, 10'h0, 1'b0);
        check("prio frm",  frm_value,    32'h7);
        check("prio ff",   fflags_value, 32'h3);
        check("prio fcsr", fcsr_value,   32'hE3);

        // frm beats fxcr; other fxcr fields still load.
        cyc(EN_FRM | EN_FXCR, 32'h0580_0022, 2'b0, 10'h0, 1'b0);
        check("frm over fxcr", frm_value, 32'h2);
        check("fxcr fields",   fxcr_value, 32'h0280_0022);

        // Full fxcr write; trap_en reads back only in the trap build.
        cyc(EN_FXCR, 32'h0780_1F25, 2'b0, 10'h0, 1'b0);
`ifdef PA_CP0_FCSR_FPE_TRAP_EN
        check("fxcr full", fxcr_value, 32'h0780_1F25);
`else
        check("fxcr full", fxcr_value, 32'h0780_0025);
`endif
        check("dqnan", {31'b0, cp0_fpu_xx_dqnan}, 32'h1);

        // Write-back coinciding with a CSR write is still merged afterwards.
        cyc(EN_FFLAGS, 32'h0, 2'b10, {5'b01000, 5'b00000}, 1'b0);
        check("coinc ff",   fflags_value, 32'h0);
        check("coinc pend", {31'b0, cp0_idu_fflags_pend}, 32'h1);
        idle();
        check("coinc merged", fflags_value, 32'h8);

`ifdef PA_CP0_FCSR_FPE_TRAP_EN
        // Trap on invalid-enable hit, hold until ack, then idle.
        cyc(EN_FXCR, 32'h0000_0100, 2'b0, 10'h0, 1'b0);
        cyc(4'b0, 32'h0, 2'b01, 10'b00000_00001, 1'b0);
        check("trap no req N+1", {31'b0, cp0_rtu_fpe_req}, 32'h0);
        idle();
        check("trap req",   {31'b0, cp0_rtu_fpe_req}, 32'h1);
        check("trap cause", {27'b0, cp0_rtu_fpe_cause}, 32'h1);
        idle();
        check("trap held", {31'b0, cp0_rtu_fpe_req}, 32'h1);
        cyc(4'b0, 32'h0, 2'b0, 10'h0, 1'b1);
        check("trap acked", {31'b0, cp0_rtu_fpe_req}, 32'h0);
        check("cause clr",  {27'b0, cp0_rtu_fpe_cause}, 32'h0);
        cyc(4'b0, 32'h0, 2'b0, 10'h0, 1'b1);
        check("ack idle ignored", {31'b0, cp0_rtu_fpe_req}, 32'h0);

        // Ack together with a new hit restarts the request with the new cause only.
        cyc(EN_FXCR, 32'h0000_0300, 2'b0, 10'h0, 1'b0);
        cyc(4'b0, 32'h0, 2'b01, 10'b00000_00010, 1'b0);
        idle();
        check("cause2", {27'b0, cp0_rtu_fpe_cause}, 32'h2);
        cyc(4'b0, 32'h0, 2'b10, {5'b00001, 5'b00000}, 1'b0);
        cyc(4'b0, 32'h0, 2'b0, 10'h0, 1'b1);
        check("ack+hit req",   {31'b0, cp0_rtu_fpe_req}, 32'h1);
        check("ack+hit cause", {27'b0, cp0_rtu_fpe_cause}, 32'h1);

        // A discarded merge raises no trap.
        cyc(4'b0, 32'h0, 2'b0, 10'h0, 1'b1);
        cyc(4'b0, 32'h0, 2'b01, 10'b00000_00001, 1'b0);
        cyc(EN_FFLAGS, 32'h0, 2'b0, 10'h0, 1'b0);
        check("discard no trap", {31'b0, cp0_rtu_fpe_req}, 32'h0);
`else
        cyc(EN_FXCR, 32'h0000_0100, 2'b0, 10'h0, 1'b0);
        cyc(4'b0, 32'h0, 2'b01, 10'b00000_00001, 1'b1);
        idle();
        check("no trap build", {26'b0, cp0_rtu_fpe_req, cp0_rtu_fpe_cause}, 32'h0);
`endif

        // Asynchronous reset drops the staged update and any request.
        cyc(4'b0, 32'h0, 2'b01, 10'b00000_00001, 1'b0);
        #1 cpurst_b = 1'b0;
        #1;
        check("rst pend", {31'b0, cp0_idu_fflags_pend}, 32'h0);
        check("rst fxcr", fxcr_value, 32'h0);
        check("rst req",  {26'b0, cp0_rtu_fpe_req, cp0_rtu_fpe_cause}, 32'h0);
        @(negedge regs_clk);
        cpurst_b = 1'b1;
        idle();
        idle();
        check("post rst ff", fflags_value, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
